// File: rtl/jbi_ncio_mrqq_ctl_if.sv
// Bundle of the mrqq controller signals: upstream push, buffer array ports, downstream issue.
// The slave modport is the controller; the master modport is its environment.
`ifndef JBI_MRQQ_WIDTH
`define JBI_MRQQ_WIDTH 64
`endif

interface jbi_ncio_mrqq_ctl_if #(
  parameter int WIDTH      = `JBI_MRQQ_WIDTH,
  parameter int ADDR_WIDTH = 4
);
  logic                  mrqq_push;
  logic [WIDTH-1:0]      mrqq_push_data;
  logic                  mrqq_full;
  logic [4:0]            mrqq_level;
  logic                  mrqq_ovf_err;
  logic                  mrqq_wr_en;
  logic [ADDR_WIDTH-1:0] mrqq_waddr;
  logic [WIDTH-1:0]      mrqq_wdata;
  logic                  mrqq_rd_en;
  logic [ADDR_WIDTH-1:0] mrqq_raddr;
  logic [WIDTH-1:0]      mrqq_rdata;
  logic                  mrqq_out_vld;
  logic [WIDTH-1:0]      mrqq_out_data;
  logic                  mrqq_out_ack;

  modport slave (
    input  mrqq_push, mrqq_push_data, mrqq_rdata, mrqq_out_ack,
    output mrqq_full, mrqq_level, mrqq_ovf_err, mrqq_wr_en, mrqq_waddr, mrqq_wdata,
           mrqq_rd_en, mrqq_raddr, mrqq_out_vld, mrqq_out_data
  );

  modport master (
    output mrqq_push, mrqq_push_data, mrqq_rdata, mrqq_out_ack,
    input  mrqq_full, mrqq_level, mrqq_ovf_err, mrqq_wr_en, mrqq_waddr, mrqq_wdata,
           mrqq_rd_en, mrqq_raddr, mrqq_out_vld, mrqq_out_data
  );
endinterface

// File: rtl/jbi_ncio_mrqq_ctl.sv
// NCIO memory-request queue controller: drives a 16-entry 1R1W array and prefetches its
// 1-cycle-latency read data into a 2-entry output stage so the consumer sees 1 word/cycle.
// Handshakes: a push is taken when mrqq_push=1 and mrqq_full=0; the head is popped when
// mrqq_out_vld=1 and mrqq_out_ack=1 (ack without valid is ignored).
`ifndef JBI_MRQQ_WIDTH
`define JBI_MRQQ_WIDTH 64
`endif

module jbi_ncio_mrqq_ctl #(
  parameter int ADDR_WIDTH = 4,
  parameter int WIDTH      = `JBI_MRQQ_WIDTH
) (
  input  logic                clk,
  input  logic                rst_l,
  jbi_ncio_mrqq_ctl_if.slave  mrqq
);

  localparam logic [ADDR_WIDTH:0] FULL_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [ADDR_WIDTH-1:0] wptr_q, rptr_q;
  logic [ADDR_WIDTH:0]   arr_cnt_q;
  logic                  inflight_q;
  logic [1:0]            out_cnt_q;
  logic [WIDTH-1:0]      head_q, tail_q;
  logic                  ovf_q;

  logic                  full;
  logic                  wr_en;
  logic                  rd_en;
  logic                  ack;
  logic [2:0]            stage_need;

  assign full  = (arr_cnt_q == FULL_CNT);
  assign wr_en = mrqq.mrqq_push & ~full;
  assign ack   = mrqq.mrqq_out_ack & (out_cnt_q != 2'd0);

  // Words already owed to the stage after this cycle's pop; a new read needs room for one more.
  assign stage_need = {1'b0, out_cnt_q} + {2'b00, inflight_q} - {2'b00, ack};
  assign rd_en      = (arr_cnt_q != '0) & (stage_need < 3'd2);

  assign mrqq.mrqq_full     = full;
  assign mrqq.mrqq_ovf_err  = ovf_q;
  assign mrqq.mrqq_wr_en    = wr_en;
  assign mrqq.mrqq_waddr    = wptr_q;
  assign mrqq.mrqq_wdata    = mrqq.mrqq_push_data;
  assign mrqq.mrqq_rd_en    = rd_en;
  assign mrqq.mrqq_raddr    = rptr_q;
  assign mrqq.mrqq_out_vld  = (out_cnt_q != 2'd0);
  assign mrqq.mrqq_out_data = head_q;
  assign mrqq.mrqq_level    = 5'(arr_cnt_q) + 5'(inflight_q) + 5'(out_cnt_q);

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      arr_cnt_q  <= '0;
      inflight_q <= 1'b0;
      out_cnt_q  <= 2'd0;
      ovf_q      <= 1'b0;
    end else begin
      if (wr_en) wptr_q <= wptr_q + 1'b1;
      if (rd_en) rptr_q <= rptr_q + 1'b1;
      arr_cnt_q  <= arr_cnt_q + {{ADDR_WIDTH{1'b0}}, wr_en} - {{ADDR_WIDTH{1'b0}}, rd_en};
      inflight_q <= rd_en;
      ovf_q      <= mrqq.mrqq_push & full;
      case ({inflight_q, ack})
        2'b10:   out_cnt_q <= out_cnt_q + 2'd1;
        2'b01:   out_cnt_q <= out_cnt_q - 2'd1;
        default: out_cnt_q <= out_cnt_q;
      endcase
    end
  end

  // Stage data needs no reset: out_cnt_q alone decides what is valid.
  always_ff @(posedge clk) begin
    case ({inflight_q, ack})
      2'b10: begin
        if (out_cnt_q == 2'd0) head_q <= mrqq.mrqq_rdata;
        else                   tail_q <= mrqq.mrqq_rdata;
      end
      2'b01: head_q <= tail_q;
      2'b11: begin
        if (out_cnt_q == 2'd1) begin
          head_q <= mrqq.mrqq_rdata;
        end else begin
          head_q <= tail_q;
          tail_q <= mrqq.mrqq_rdata;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_jbi_ncio_mrqq_ctl.sv
// Directed bench for jbi_ncio_mrqq_ctl with a behavioural 16-entry array (1-cycle read).
// Inputs change 1ns after the rising edge; outputs are sampled 2ns after it.
module tb_jbi_ncio_mrqq_ctl;
  localparam int W = 64;

  logic clk;
  logic rst_l;
  int   checks;
  int   errors;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mem [16];

  jbi_ncio_mrqq_ctl_if #(.WIDTH(W), .ADDR_WIDTH(4)) m ();

  jbi_ncio_mrqq_ctl #(.ADDR_WIDTH(4), .WIDTH(W)) dut (
    .clk   (clk),
    .rst_l (rst_l),
    .mrqq  (m)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (m.mrqq_wr_en) mem[m.mrqq_waddr] <= m.mrqq_wdata;
    if (m.mrqq_rd_en) m.mrqq_rdata <= mem[m.mrqq_raddr];
  end

  always @(posedge clk) begin
    if (rst_l) begin
      assert (!(m.mrqq_out_ack && !m.mrqq_out_vld))
        else $error("FAIL ack_without_vld: ack=1 while out_vld=0");
    end
  end

  // driver tasks
  task automatic set_in(input logic p, input logic [W-1:0] d, input logic a);
    m.mrqq_push      = p;
    m.mrqq_push_data = d;
    m.mrqq_out_ack   = a;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_l = 1'b0;
    set_in(1'b0, '0, 1'b0);
    tick();
    tick();
    rst_l = 1'b1;
    exp_q.delete();
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      if (m.mrqq_out_vld) begin
        checks++;
        if (m.mrqq_out_data !== exp_q[0]) begin
          errors++;
          $display("FAIL %s_order: got %h want %h", tag, m.mrqq_out_data, exp_q[0]);
        end
        void'(exp_q.pop_front());
        set_in(1'b0, '0, 1'b1);
      end else begin
        set_in(1'b0, '0, 1'b0);
      end
      tick();
      n++;
    end
    set_in(1'b0, '0, 1'b0);
    checks++;
    if (exp_q.size() != 0 || m.mrqq_level !== 5'd0) begin
      errors++;
      $display("FAIL %s_drain: left=%0d level=%0d want 0/0", tag, exp_q.size(), m.mrqq_level);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({m.mrqq_level, m.mrqq_out_vld, m.mrqq_full, m.mrqq_ovf_err, m.mrqq_rd_en, m.mrqq_wr_en} !== 10'd0) begin
      errors++;
      $display("FAIL reset_state: level=%0d vld=%b full=%b ovf=%b rd=%b wr=%b want all 0",
               m.mrqq_level, m.mrqq_out_vld, m.mrqq_full, m.mrqq_ovf_err, m.mrqq_rd_en, m.mrqq_wr_en);
    end
  endtask

  task automatic test_single();
    do_reset();
    set_in(1'b1, 64'hA5, 1'b0);
    checks++;
    if (m.mrqq_wr_en !== 1'b1 || m.mrqq_waddr !== 4'd0 || m.mrqq_rd_en !== 1'b0) begin
      errors++;
      $display("FAIL single_c0: wr=%b waddr=%0d rd=%b want 1/0/0", m.mrqq_wr_en, m.mrqq_waddr, m.mrqq_rd_en);
    end
    tick();
    set_in(1'b0, '0, 1'b0);
    checks++;
    if (m.mrqq_rd_en !== 1'b1 || m.mrqq_raddr !== 4'd0 || m.mrqq_level !== 5'd1) begin
      errors++;
      $display("FAIL single_c1: rd=%b raddr=%0d level=%0d want 1/0/1", m.mrqq_rd_en, m.mrqq_raddr, m.mrqq_level);
    end
    tick();
    checks++;
    if (m.mrqq_out_vld !== 1'b0 || m.mrqq_level !== 5'd1) begin
      errors++;
      $display("FAIL single_c2: vld=%b level=%0d want 0/1", m.mrqq_out_vld, m.mrqq_level);
    end
    tick();
    checks++;
    if (m.mrqq_out_vld !== 1'b1 || m.mrqq_out_data !== 64'hA5) begin
      errors++;
      $display("FAIL single_c3: vld=%b data=%h want 1/a5", m.mrqq_out_vld, m.mrqq_out_data);
    end
    set_in(1'b0, '0, 1'b1);
    tick();
    set_in(1'b0, '0, 1'b0);
    checks++;
    if (m.mrqq_out_vld !== 1'b0 || m.mrqq_level !== 5'd0) begin
      errors++;
      $display("FAIL single_pop: vld=%b level=%0d want 0/0", m.mrqq_out_vld, m.mrqq_level);
    end
  endtask

  task automatic test_fill_overflow();
    do_reset();
    for (int k = 0; k < 16; k++) begin
      set_in(1'b1, 64'h200 + 64'(k), 1'b0);
      exp_q.push_back(64'h200 + 64'(k));
      tick();
    end
    set_in(1'b0, '0, 1'b0);
    checks++;
    if (m.mrqq_level !== 5'd16 || m.mrqq_full !== 1'b0 || m.mrqq_out_vld !== 1'b1) begin
      errors++;
      $display("FAIL fill16: level=%0d full=%b vld=%b want 16/0/1", m.mrqq_level, m.mrqq_full, m.mrqq_out_vld);
    end
    for (int k = 16; k < 18; k++) begin
      set_in(1'b1, 64'h200 + 64'(k), 1'b0);
      exp_q.push_back(64'h200 + 64'(k));
      checks++;
      if (m.mrqq_wr_en !== 1'b1 || m.mrqq_full !== 1'b0) begin
        errors++;
        $display("FAIL fill_push%0d: wr=%b full=%b want 1/0", k, m.mrqq_wr_en, m.mrqq_full);
      end
      tick();
    end
    set_in(1'b1, 64'hDEAD, 1'b0);
    checks++;
    if (m.mrqq_full !== 1'b1 || m.mrqq_level !== 5'd18 || m.mrqq_wr_en !== 1'b0 || m.mrqq_ovf_err !== 1'b0) begin
      errors++;
      $display("FAIL full_state: full=%b level=%0d wr=%b ovf=%b want 1/18/0/0",
               m.mrqq_full, m.mrqq_level, m.mrqq_wr_en, m.mrqq_ovf_err);
    end
    tick();
    set_in(1'b0, '0, 1'b0);
    checks++;
    if (m.mrqq_ovf_err !== 1'b1 || m.mrqq_level !== 5'd18) begin
      errors++;
      $display("FAIL ovf_pulse: ovf=%b level=%0d want 1/18", m.mrqq_ovf_err, m.mrqq_level);
    end
    tick();
    checks++;
    if (m.mrqq_ovf_err !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear: ovf=%b want 0", m.mrqq_ovf_err);
    end
    drain("fill");
  endtask

  task automatic test_back_to_back();
    logic [3:0] wa;
    logic [3:0] ra;
    int bad;
    do_reset();
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      wa = 4'(i);
      ra = 4'(i - 1);
      set_in(1'b1, 64'h100 + 64'(i), m.mrqq_out_vld);
      exp_q.push_back(64'h100 + 64'(i));
      checks++;
      if (m.mrqq_wr_en !== 1'b1 || m.mrqq_waddr !== wa) begin
        errors++;
        $display("FAIL stream_wr c%0d: wr=%b waddr=%0d want 1/%0d", i, m.mrqq_wr_en, m.mrqq_waddr, wa);
      end
      if (i >= 1) begin
        checks++;
        if (m.mrqq_rd_en !== 1'b1 || m.mrqq_raddr !== ra) begin
          errors++;
          $display("FAIL stream_rd c%0d: rd=%b raddr=%0d want 1/%0d", i, m.mrqq_rd_en, m.mrqq_raddr, ra);
        end
      end
      if (i >= 3) begin
        checks++;
        if (m.mrqq_out_vld !== 1'b1 || m.mrqq_out_data !== exp_q[0] || m.mrqq_level !== 5'd3) begin
          errors++;
          $display("FAIL stream_out c%0d: vld=%b data=%h level=%0d want 1/%h/3",
                   i, m.mrqq_out_vld, m.mrqq_out_data, m.mrqq_level, exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
      tick();
    end
    drain("stream");
  endtask

  task automatic test_stall();
    int issued;
    int acked;
    int n;
    logic a;
    logic flag;
    do_reset();
    issued = 0;
    acked  = 0;
    flag   = 1'b0;
    for (int k = 0; k < 5; k++) begin
      set_in(1'b1, 64'h500 + 64'(k), 1'b0);
      exp_q.push_back(64'h500 + 64'(k));
      if (m.mrqq_rd_en) issued++;
      tick();
    end
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      flag = ~flag;
      a = flag & m.mrqq_out_vld;
      set_in(1'b0, '0, a);
      if (a) begin
        checks++;
        if (m.mrqq_out_data !== exp_q[0]) begin
          errors++;
          $display("FAIL stall_order: got %h want %h", m.mrqq_out_data, exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
      if (m.mrqq_rd_en) begin
        checks++;
        if (issued - acked - int'(a) >= 2) begin
          errors++;
          $display("FAIL stall_rd_room: rd=1 with %0d owed want <2", issued - acked - int'(a));
        end
        issued++;
      end
      if (a) acked++;
      tick();
      n++;
    end
    set_in(1'b0, '0, 1'b0);
    checks++;
    if (exp_q.size() != 0 || acked != 5 || issued != 5 || m.mrqq_level !== 5'd0) begin
      errors++;
      $display("FAIL stall_count: left=%0d acked=%0d issued=%0d level=%0d want 0/5/5/0",
               exp_q.size(), acked, issued, m.mrqq_level);
    end
  endtask

  task automatic test_simul_push_ack();
    do_reset();
    set_in(1'b1, 64'h400, 1'b0);
    exp_q.push_back(64'h400);
    tick();
    set_in(1'b0, '0, 1'b0);
    tick();
    tick();
    set_in(1'b1, 64'h401, 1'b0);
    exp_q.push_back(64'h401);
    checks++;
    if (m.mrqq_out_vld !== 1'b1 || m.mrqq_level !== 5'd1 || m.mrqq_rd_en !== 1'b0) begin
      errors++;
      $display("FAIL simul_setup: vld=%b level=%0d rd=%b want 1/1/0", m.mrqq_out_vld, m.mrqq_level, m.mrqq_rd_en);
    end
    tick();
    set_in(1'b1, 64'h402, 1'b1);
    exp_q.push_back(64'h402);
    checks++;
    if (m.mrqq_out_data !== exp_q[0] || m.mrqq_wr_en !== 1'b1 || m.mrqq_rd_en !== 1'b1 || m.mrqq_level !== 5'd2) begin
      errors++;
      $display("FAIL simul_cycle: data=%h wr=%b rd=%b level=%0d want %h/1/1/2",
               m.mrqq_out_data, m.mrqq_wr_en, m.mrqq_rd_en, m.mrqq_level, exp_q[0]);
    end
    void'(exp_q.pop_front());
    tick();
    set_in(1'b0, '0, 1'b0);
    checks++;
    if (m.mrqq_level !== 5'd2 || m.mrqq_out_vld !== 1'b0) begin
      errors++;
      $display("FAIL simul_after: level=%0d vld=%b want 2/0", m.mrqq_level, m.mrqq_out_vld);
    end
    drain("simul");
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int k = 0; k < 8; k++) begin
      set_in(1'b1, 64'h300 + 64'(k), 1'b0);
      tick();
    end
    set_in(1'b0, '0, 1'b0);
    tick();
    tick();
    set_in(1'b0, '0, 1'b1);
    checks++;
    if (m.mrqq_out_data !== 64'h300 || m.mrqq_level !== 5'd8) begin
      errors++;
      $display("FAIL rstmid_pre: data=%h level=%0d want 300/8", m.mrqq_out_data, m.mrqq_level);
    end
    tick();
    set_in(1'b0, '0, 1'b0);
    checks++;
    if (m.mrqq_level !== 5'd7) begin
      errors++;
      $display("FAIL rstmid_level7: level=%0d want 7", m.mrqq_level);
    end
    rst_l = 1'b0;
    tick();
    rst_l = 1'b1;
    checks++;
    if (m.mrqq_level !== 5'd0 || m.mrqq_out_vld !== 1'b0 || m.mrqq_full !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_clear: level=%0d vld=%b full=%b want 0/0/0", m.mrqq_level, m.mrqq_out_vld, m.mrqq_full);
    end
    set_in(1'b1, 64'h3C, 1'b0);
    tick();
    set_in(1'b0, '0, 1'b0);
    tick();
    checks++;
    if (m.mrqq_out_vld !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_early: vld=%b in cycle 2 want 0", m.mrqq_out_vld);
    end
    tick();
    checks++;
    if (m.mrqq_out_vld !== 1'b1 || m.mrqq_out_data !== 64'h3C) begin
      errors++;
      $display("FAIL rstmid_first: vld=%b data=%h want 1/3c", m.mrqq_out_vld, m.mrqq_out_data);
    end
    set_in(1'b0, '0, 1'b1);
    tick();
    set_in(1'b0, '0, 1'b0);
    checks++;
    if (m.mrqq_out_vld !== 1'b0 || m.mrqq_level !== 5'd0) begin
      errors++;
      $display("FAIL rstmid_pop: vld=%b level=%0d want 0/0", m.mrqq_out_vld, m.mrqq_level);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_l  = 1'b0;
    m.mrqq_push      = 1'b0;
    m.mrqq_push_data = '0;
    m.mrqq_out_ack   = 1'b0;
    #1;
    tick();
    test_reset();
    test_single();
    test_fill_overflow();
    test_back_to_back();
    test_stall();
    test_simul_push_ack();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
